sdram_responder: RTL and testbench

Synthesizable responder for the 16-bit single-data-rate SDRAM command bus (MT48LC16M16-style pins) that our SDRAM controllers drive. It decodes ACTIVE/READ/WRITE/PRECHARGE/AUTO_REFRESH/LOAD_MODE commands, tracks open rows per bank, and serves reads and writes from on-chip block RAM with the programmed CAS latency. It stands in for the external chip in on-FPGA loopback benches and simulation, and flags protocol violations so controller bugs surface as sticky error bits.

---
 rtl/sdram_responder_if.sv | 28 ++
 rtl/sdram_responder.sv | 149 ++++++++++++++
 tb/tb_sdram_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a controller (master)
// and the responder model (slave).
interface sdram_responder_if;
    logic        cke;
    logic        ncs;
    logic        nras;
    logic        ncas;
    logic        nwe;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        dqml;
    logic        dqmh;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output cke, ncs, nras, ncas, nwe,
        output ba, a, dqml, dqmh, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  cke, ncs, nras, ncas, nwe,
        input  ba, a, dqml, dqmh, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM chip stand-in: bank/row tracking, CAS-latency read
// pipeline, byte-masked writes and sticky protocol error flags.
module sdram_responder #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 8,
    parameter int TRCD     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_responder_if.slave bus,
    output logic [1:0]  cas_lat,
    output logic [15:0] refresh_cnt,
    output logic [3:0]  err,
    input  logic        err_clr
);

    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;

    logic [15:0]   mem [2**AW];
    logic [15:0]   mem_rd;

    logic [3:0]    open_q;
    logic [12:0]   row_q  [4];
    logic [TW-1:0] trcd_q [4];

    logic          s0_v;
    logic [1:0]    s0_m;
    logic          s1_v;
    logic [1:0]    s1_m;
    logic [15:0]   s1_d;
    logic [15:0]   dq_out_q;
    logic          dq_oe_q;

    logic [3:0]    cmd;
    logic          go;
    logic          is_lmr, is_ref, is_pre;
    logic          is_act, is_wr, is_rd;
    logic          bank_open, bank_busy, any_open;
    logic          acc_ok, mode_ok;
    logic [12:0]   row_cur;
    logic [AW-1:0] idx;
    logic [3:0]    viol;
    logic          sel_v;
    logic [1:0]    sel_m;
    logic [15:0]   sel_d;
    logic [15:0]   sel_masked;

    assign cmd    = {bus.ncs, bus.nras, bus.ncas, bus.nwe};
    assign go     = bus.cke & ~bus.ncs;
    assign is_lmr = go && cmd == C_LMR;
    assign is_ref = go && cmd == C_REF;
    assign is_pre = go && cmd == C_PRE;
    assign is_act = go && cmd == C_ACT;
    assign is_wr  = go && cmd == C_WR;
    assign is_rd  = go && cmd == C_RD;

    assign bank_open = open_q[bus.ba];
    assign bank_busy = trcd_q[bus.ba] != '0;
    assign any_open  = |open_q;
    assign acc_ok    = (is_rd | is_wr) & bank_open;
    assign mode_ok   = bus.a[2:0] == 3'b000 &&
                       (bus.a[6:4] == 3'd2 || bus.a[6:4] == 3'd3);

    assign row_cur = row_q[bus.ba];
    assign idx = {bus.ba, row_cur[ROW_BITS-1:0],
                  bus.a[COL_BITS-1:0]};

    assign viol[0] = is_act & bank_open;
    assign viol[1] = (is_rd | is_wr) & (~bank_open | bank_busy);
    assign viol[2] = is_ref & any_open;
    assign viol[3] = is_lmr & (any_open | ~mode_ok);

    // CL2 takes data one stage earlier than CL3
    assign sel_v = (cas_lat == 2'd3) ? s1_v : s0_v;
    assign sel_m = (cas_lat == 2'd3) ? s1_m : s0_m;
    assign sel_d = (cas_lat == 2'd3) ? s1_d : mem_rd;
    assign sel_masked = {sel_m[1] ? 8'h00 : sel_d[15:8],
                         sel_m[0] ? 8'h00 : sel_d[7:0]};

    assign bus.dq_out = dq_out_q;
    assign bus.dq_oe  = dq_oe_q;

    // Memory has no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (acc_ok && is_wr) begin
            if (!bus.dqml) mem[idx][7:0]  <= bus.dq_in[7:0];
            if (!bus.dqmh) mem[idx][15:8] <= bus.dq_in[15:8];
        end
        if (is_rd) mem_rd <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q      <= '0;
            for (int b = 0; b < 4; b++) begin
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
            s0_v        <= 1'b0;
            s0_m        <= '0;
            s1_v        <= 1'b0;
            s1_m        <= '0;
            s1_d        <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            cas_lat     <= 2'd2;
            refresh_cnt <= '0;
            err         <= '0;
        end else begin
            err <= (err_clr ? 4'b0000 : err) | viol;
            if (bus.cke) begin
                for (int b = 0; b < 4; b++)
                    if (trcd_q[b] != '0)
                        trcd_q[b] <= trcd_q[b] - 1'b1;
                if (is_act) begin
                    open_q[bus.ba] <= 1'b1;
                    row_q[bus.ba]  <= bus.a;
                    trcd_q[bus.ba] <= TW'(TRCD - 1);
                end
                if (acc_ok && bus.a[10])
                    open_q[bus.ba] <= 1'b0;
                if (is_pre) begin
                    if (bus.a[10]) open_q <= '0;
                    else           open_q[bus.ba] <= 1'b0;
                end
                if (is_ref)
                    refresh_cnt <= refresh_cnt + 16'd1;
                if (is_lmr && mode_ok)
                    cas_lat <= bus.a[5:4];
                s0_v     <= is_rd & bank_open;
                s0_m     <= {bus.dqmh, bus.dqml};
                s1_v     <= s0_v;
                s1_m     <= s0_m;
                s1_d     <= mem_rd;
                dq_oe_q  <= sel_v;
                dq_out_q <= sel_v ? sel_masked : 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: mode register, reads/writes,
// masks, protocol errors, refresh and reset during reads.
module tb_sdram_responder;

    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cas_lat;
    logic [15:0] refresh_cnt;
    logic [3:0]  err;
    logic        err_clr;
    int          n_chk = 0;
    int          n_err = 0;

    sdram_responder_if bus ();

    sdram_responder #(
        .ROW_BITS(6), .COL_BITS(8), .TRCD(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cas_lat(cas_lat),
        .refresh_cnt(refresh_cnt),
        .err(err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic nop();
        {bus.ncs, bus.nras, bus.ncas, bus.nwe} = 4'b0111;
        bus.dqml = 1'b0;
        bus.dqmh = 1'b0;
    endtask

    task automatic do_cmd(input logic [3:0]  c,
                          input logic [1:0]  b,
                          input logic [12:0] ad,
                          input logic [15:0] d,
                          input logic [1:0]  m);
        {bus.ncs, bus.nras, bus.ncas, bus.nwe} = c;
        bus.ba    = b;
        bus.a     = ad;
        bus.dq_in = d;
        {bus.dqmh, bus.dqml} = m;
        tick(1);
        nop();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic read_chk(input string tag,
                            input logic [1:0] b,
                            input logic [8:0] col,
                            input logic [1:0] m,
                            input int cl,
                            input logic [15:0] exp);
        do_cmd(RD, b, {4'h0, col}, 16'h0, m);
        chk({tag, "_early"}, 32'(bus.dq_oe), 32'd0);
        tick(cl - 1);
        chk({tag, "_oe"}, 32'(bus.dq_oe), 32'd1);
        chk({tag, "_data"}, 32'(bus.dq_out), 32'(exp));
        tick(1);
        chk({tag, "_oe_drop"}, 32'(bus.dq_oe), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        err_clr   = 1'b0;
        bus.cke   = 1'b1;
        bus.ba    = '0;
        bus.a     = '0;
        bus.dq_in = '0;
        nop();
        tick(2);
        chk("rst_cl", 32'(cas_lat), 32'd2);
        chk("rst_ref", 32'(refresh_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_oe", 32'(bus.dq_oe), 32'd0);
        chk("rst_dq", 32'(bus.dq_out), 32'd0);
        rst_n = 1'b1;
        tick(1);

        do_cmd(LMR, 2'd0, 13'h220, 16'h0, 2'b00);
        chk("lmr_cl2", 32'(cas_lat), 32'd2);
        chk("lmr_cl2_err", 32'(err), 32'd0);
        do_cmd(LMR, 2'd0, 13'h230, 16'h0, 2'b00);
        chk("lmr_cl3", 32'(cas_lat), 32'd3);
        do_cmd(LMR, 2'd0, 13'h241, 16'h0, 2'b00);
        chk("lmr_bad_err", 32'(err), 32'h8);
        chk("lmr_bad_cl", 32'(cas_lat), 32'd3);
        clear_err();
        chk("lmr_clr", 32'(err), 32'd0);
        do_cmd(LMR, 2'd0, 13'h220, 16'h0, 2'b00);
        chk("lmr_back", 32'(cas_lat), 32'd2);

        do_cmd(ACT, 2'd1, 13'd5, 16'h0, 2'b00);
        tick(1);
        do_cmd(WR, 2'd1, 13'h010, 16'hA55A, 2'b00);
        read_chk("rd_a55a", 2'd1, 9'h010, 2'b00, 2, 16'hA55A);
        chk("rd_a55a_err", 32'(err), 32'd0);

        do_cmd(WR, 2'd1, 13'h020, 16'h1234, 2'b00);
        do_cmd(WR, 2'd1, 13'h020, 16'hFFFF, 2'b10);
        read_chk("rd_dqmh_wr", 2'd1, 9'h020, 2'b00, 2, 16'h12FF);
        read_chk("rd_dqml", 2'd1, 9'h020, 2'b01, 2, 16'h1200);

        do_cmd(ACT, 2'd1, 13'd5, 16'h0, 2'b00);
        chk("act_open_err", 32'(err), 32'h1);
        clear_err();

        do_cmd(RD, 2'd2, 13'h010, 16'h0, 2'b00);
        chk("rd_closed_err", 32'(err), 32'h2);
        for (int i = 0; i < 3; i++) begin
            chk("rd_closed_oe", 32'(bus.dq_oe), 32'd0);
            tick(1);
        end
        clear_err();
        chk("rd_closed_clr", 32'(err), 32'd0);

        do_cmd(ACT, 2'd3, 13'd7, 16'h0, 2'b00);
        tick(1);
        do_cmd(WR, 2'd3, 13'h405, 16'hBEEF, 2'b00);
        chk("wr_ap_err", 32'(err), 32'd0);
        do_cmd(ACT, 2'd3, 13'd7, 16'h0, 2'b00);
        chk("act_after_ap", 32'(err), 32'd0);
        read_chk("rd_trcd", 2'd3, 9'h005, 2'b00, 2, 16'hBEEF);
        chk("rd_trcd_err", 32'(err), 32'h2);
        clear_err();

        do_cmd(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        repeat (3) do_cmd(REF, 2'd0, 13'h0, 16'h0, 2'b00);
        chk("ref3_cnt", 32'(refresh_cnt), 32'd3);
        chk("ref3_err", 32'(err), 32'd0);
        do_cmd(ACT, 2'd0, 13'd0, 16'h0, 2'b00);
        do_cmd(REF, 2'd0, 13'h0, 16'h0, 2'b00);
        chk("ref_open_err", 32'(err), 32'h4);
        chk("ref_open_cnt", 32'(refresh_cnt), 32'd4);
        do_cmd(PRE, 2'd2, 13'h400, 16'h0, 2'b00);
        clear_err();
        do_cmd(REF, 2'd0, 13'h0, 16'h0, 2'b00);
        chk("pre_all_err", 32'(err), 32'd0);
        chk("pre_all_cnt", 32'(refresh_cnt), 32'd5);

        do_cmd(LMR, 2'd0, 13'h030, 16'h0, 2'b00);
        chk("cl3_set", 32'(cas_lat), 32'd3);
        do_cmd(ACT, 2'd1, 13'd5, 16'h0, 2'b00);
        tick(1);
        read_chk("rd_cl3", 2'd1, 9'h010, 2'b00, 3, 16'hA55A);

        do_cmd(RD, 2'd1, 13'h010, 16'h0, 2'b00);
        do_cmd(RD, 2'd1, 13'h020, 16'h0, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(bus.dq_oe), 32'd0);
        do_cmd(RD, 2'd1, 13'h010, 16'h0, 2'b00);
        do_cmd(RD, 2'd1, 13'h020, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("rst_hold_oe", 32'(bus.dq_oe), 32'd0);
            tick(1);
        end
        chk("rst_mid_cl", 32'(cas_lat), 32'd2);
        chk("rst_mid_ref", 32'(refresh_cnt), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_oe", 32'(bus.dq_oe), 32'd0);
        do_cmd(ACT, 2'd1, 13'd5, 16'h0, 2'b00);
        tick(1);
        read_chk("rd_post_rst", 2'd1, 9'h020, 2'b00, 2, 16'h12FF);
        chk("post_rst_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
